// File: rtl/key_pkg.sv
// Shared constants for the push-button conditioning blocks.
// Latency: none (package only).
// Backpressure: none (package only).
package key_pkg;

    // Debouncer FSM state encoding
    localparam logic [1:0] ST_RELEASED      = 2'd0;
    localparam logic [1:0] ST_PRESS_CHECK   = 2'd1;
    localparam logic [1:0] ST_PRESSED       = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHECK = 2'd3;

    // Default timing at 50 MHz
    localparam int DEB_5MS_50MHZ = 250000;
    localparam int LONG_1S_50MHZ = 50000000;

    // Bits needed to hold 0..max_val; never less than one bit so a
    // disabled (zero-length) timer still has a legal register.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debouncer_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Latency: 2 CLOCK_50 edges from d to q.
// Backpressure: none; q follows d continuously.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture and re-time the raw level; reset loads the idle level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronizer, debounce FSM, press/release/long-press pulses.
// Latency: press_pulse high in the cycle after edge DEBOUNCE_CYCLES+2 of a stable press.
// Backpressure: none; all outputs are registered one-cycle events or levels.
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEB_5MS_50MHZ,
    parameter int LONG_PRESS_CYCLES = LONG_1S_50MHZ,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_PRESS_CYCLES);
    localparam bit            LONG_EN   = (LONG_PRESS_CYCLES > 0);

    logic          sync_q;
    logic          k_s;
    logic [1:0]    state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [LW-1:0] lcnt, lcnt_nxt;
    logic          long_fired, long_fired_nxt;
    logic          press_nxt, release_nxt, long_nxt, level_nxt;

    // Sync flops idle at the released electrical level
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d        (key_in),
        .q        (sync_q)
    );

    assign k_s = ACTIVE_LOW ? ~sync_q : sync_q;

    // State, counters and registered outputs; reset wins over everything
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state            <= ST_RELEASED;
            dcnt             <= '0;
            lcnt             <= '0;
            long_fired       <= 1'b0;
            key_level        <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            state            <= state_nxt;
            dcnt             <= dcnt_nxt;
            lcnt             <= lcnt_nxt;
            long_fired       <= long_fired_nxt;
            key_level        <= level_nxt;
            press_pulse      <= press_nxt;
            release_pulse    <= release_nxt;
            long_press_pulse <= long_nxt;
        end
    end

    // Next-state: a level change is accepted only after DEBOUNCE_CYCLES stable samples
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RELEASED: begin
                if (k_s) state_nxt = ST_PRESS_CHECK;
            end
            ST_PRESS_CHECK: begin
                if (!k_s)                   state_nxt = ST_RELEASED;
                else if (dcnt == DCNT_LAST) state_nxt = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!k_s) state_nxt = ST_RELEASE_CHECK;
            end
            ST_RELEASE_CHECK: begin
                if (k_s)                    state_nxt = ST_PRESSED;
                else if (dcnt == DCNT_LAST) state_nxt = ST_RELEASED;
            end
            default: state_nxt = ST_RELEASED;
        endcase
    end

    // Counters and pulse generation; lcnt survives release bounces
    always_comb begin
        dcnt_nxt       = dcnt;
        lcnt_nxt       = lcnt;
        long_fired_nxt = long_fired;
        press_nxt      = 1'b0;
        release_nxt    = 1'b0;
        long_nxt       = 1'b0;
        level_nxt      = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_CHECK);
        case (state)
            ST_RELEASED: begin
                dcnt_nxt = '0;
            end
            ST_PRESS_CHECK: begin
                if (!k_s) begin
                    dcnt_nxt = '0;
                end else if (dcnt == DCNT_LAST) begin
                    press_nxt      = 1'b1;
                    lcnt_nxt       = '0;
                    long_fired_nxt = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                dcnt_nxt = '0;
                if (k_s && (lcnt != LCNT_MAX)) lcnt_nxt = lcnt + 1'b1;
                if (LONG_EN && (lcnt == LCNT_LAST) && !long_fired) begin
                    long_nxt       = 1'b1;
                    long_fired_nxt = 1'b1;
                end
            end
            ST_RELEASE_CHECK: begin
                if (!k_s) begin
                    if (dcnt == DCNT_LAST) release_nxt = 1'b1;
                    else                   dcnt_nxt    = dcnt + 1'b1;
                end
            end
            default: begin
                dcnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_key_debouncer;
    import key_pkg::*;

    logic CLOCK_50;
    logic reset;
    logic key_in;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    int total = 0;
    int bad   = 0;

    key_debouncer #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .key_in           (key_in),
        .key_level        (key_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, key_level, press_pulse, release_pulse, long_press_pulse};
    endfunction

    // Run n cycles. keys[i-1] is applied before tick i (so tick 1 samples edge 0).
    // p_at/r_at/lp_at: tick after which that pulse must be high (0 = never).
    // Level starts at lvl0 and flips from tick lvl_sw on (0 = never).
    task automatic seg(input string tag, input int n, input logic [63:0] keys,
                       input int p_at, input int r_at, input int lp_at,
                       input logic lvl0, input int lvl_sw);
        logic lvl;
        for (int i = 1; i <= n; i++) begin
            key_in = keys[i-1];
            tick();
            lvl = (lvl_sw > 0 && i >= lvl_sw) ? ~lvl0 : lvl0;
            check($sformatf("%s[%0d]", tag, i), outs(),
                  {28'd0, lvl, (i == p_at), (i == r_at), (i == lp_at)});
        end
    endtask

    initial begin
        reset  = 1'b1;
        key_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_outs[%0d]", i), outs(), 32'd0);
        end
        reset = 1'b0;
        seg("idle", 3, {64{1'b1}}, 0, 0, 0, 1'b0, 0);
        check("reset_state", {30'd0, dut.state}, {30'd0, ST_RELEASED});

        // Press bounce: 0,0,0,1,0,0 then released
        seg("press_bounce", 12, ~64'h37, 0, 0, 0, 1'b0, 0);

        // Clean press held: accepted after tick 7, long press 20 cycles later
        seg("press_hold", 37, 64'h0, 7, 0, 27, 1'b0, 7);

        // Release bounce: released for 2 samples, then pressed again
        seg("release_bounce", 10, 64'h3, 0, 0, 0, 1'b1, 0);

        // Clean release
        seg("release", 10, {64{1'b1}}, 0, 7, 0, 1'b1, 7);

        // Press again, then reset while held
        seg("press2", 10, 64'h0, 7, 0, 0, 1'b0, 7);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("mid_reset[%0d]", i), outs(), 32'd0);
        end
        reset = 1'b0;

        // Key still held: a fresh press after full debounce, no release event
        seg("after_reset", 12, 64'h0, 7, 0, 0, 1'b0, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
